// File: rtl/imgproc_msg_poller.sv
// imgproc_msg_poller: polls an MM message mailbox and emits bounding boxes.
module imgproc_msg_poller #(
   parameter int unsigned POLL_INTERVAL = 1024,
   parameter logic [23:0] BB_COL_INIT   = 24'hFF00FF,
   parameter logic [31:0] MSG_ID        = 32'h00524242
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic        m_chipselect,
   output logic        m_read,
   output logic        m_write,
   output logic [2:0]  m_address,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic        bb_valid,
   input  logic        bb_ready,
   output logic [10:0] bb_xmin,
   output logic [10:0] bb_ymin,
   output logic [10:0] bb_xmax,
   output logic [10:0] bb_ymax,
   output logic        resync
);
   localparam logic [3:0] CFG = 4'd0, IDLE = 4'd1, RD_STAT = 4'd2, CAP_STAT = 4'd3,
                          RD_W0 = 4'd4, CAP_W0 = 4'd5, RD_W1 = 4'd6, CAP_W1 = 4'd7,
                          RD_W2 = 4'd8, CAP_W2 = 4'd9, FLUSH = 4'd10, OUT = 4'd11;
   localparam logic [15:0] CNT_INIT = 16'(POLL_INTERVAL - 1);

   logic [3:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        m_read_q, m_read_d, m_write_q, m_write_d;
   logic [2:0]  m_address_q, m_address_d;
   logic [31:0] m_writedata_q, m_writedata_d;
   logic        bb_valid_q, bb_valid_d, resync_q, resync_d;
   logic [10:0] xmin_q, xmin_d, ymin_q, ymin_d, xmax_q, xmax_d, ymax_q, ymax_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = state_q != IDLE ? CNT_INIT : (cnt_q != 16'd0 ? cnt_q - 16'd1 : cnt_q);
      case (state_q)
         CFG:      state_d = m_write_q ? IDLE : CFG;
         IDLE:     state_d = (cnt_q == 16'd0 && enable) ? RD_STAT : IDLE;
         RD_STAT:  state_d = CAP_STAT;
         CAP_STAT: state_d = m_readdata[15:8] >= 8'd3 ? RD_W0 : IDLE;
         RD_W0:    state_d = CAP_W0;
         CAP_W0:   state_d = m_readdata == MSG_ID ? RD_W1 : FLUSH;
         RD_W1:    state_d = CAP_W1;
         CAP_W1:   state_d = RD_W2;
         RD_W2:    state_d = CAP_W2;
         CAP_W2:   state_d = OUT;
         FLUSH:    state_d = IDLE;
         OUT:      state_d = bb_ready ? IDLE : OUT;
         default:  state_d = CFG;
      endcase
      // MM outputs are registered from the next state so each strobe lines up with its state
      m_read_d      = state_d inside {RD_STAT, RD_W0, RD_W1, RD_W2};
      m_write_d     = state_d inside {CFG, FLUSH};
      m_address_d   = state_d == CFG ? 3'd3 : (state_d inside {RD_W0, RD_W1, RD_W2} ? 3'd1 : 3'd0);
      m_writedata_d = state_d == CFG ? {8'h00, BB_COL_INIT} : (state_d == FLUSH ? 32'h00000010 : 32'd0);
      resync_d      = state_d == FLUSH;
      bb_valid_d    = state_d == OUT;
      xmin_d        = state_q == CAP_W1 ? m_readdata[26:16] : xmin_q;
      ymin_d        = state_q == CAP_W1 ? m_readdata[10:0]  : ymin_q;
      xmax_d        = state_q == CAP_W2 ? m_readdata[26:16] : xmax_q;
      ymax_d        = state_q == CAP_W2 ? m_readdata[10:0]  : ymax_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q       <= CFG;
         cnt_q         <= CNT_INIT;
         m_read_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_address_q   <= 3'd0;
         m_writedata_q <= 32'd0;
         resync_q      <= 1'b0;
         bb_valid_q    <= 1'b0;
         xmin_q        <= 11'd0;
         ymin_q        <= 11'd0;
         xmax_q        <= 11'd0;
         ymax_q        <= 11'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         m_read_q      <= m_read_d;
         m_write_q     <= m_write_d;
         m_address_q   <= m_address_d;
         m_writedata_q <= m_writedata_d;
         resync_q      <= resync_d;
         bb_valid_q    <= bb_valid_d;
         xmin_q        <= xmin_d;
         ymin_q        <= ymin_d;
         xmax_q        <= xmax_d;
         ymax_q        <= ymax_d;
      end

   assign m_chipselect = m_read_q | m_write_q;
   assign m_read       = m_read_q;
   assign m_write      = m_write_q;
   assign m_address    = m_address_q;
   assign m_writedata  = m_writedata_q;
   assign resync       = resync_q;
   assign bb_valid     = bb_valid_q;
   assign bb_xmin      = xmin_q;
   assign bb_ymin      = ymin_q;
   assign bb_xmax      = xmax_q;
   assign bb_ymax      = ymax_q;
endmodule
